// File: rtl/mipi_lane_merger.sv
// mipi_lane_merger: re-serialises deskewed multi-lane words into one byte per
// byte_clk in D-PHY lane order (lane0 first), with sop/eop framing derived
// from gaps in the input valid. A one-word hold stage tags each word with
// "last" one cycle late, and a first-word-fallthrough FIFO absorbs the LANES:1
// rate mismatch. The sink has no backpressure, so FIFO overflow drops words.
module mipi_lane_merger #(
  parameter int LANES      = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                             byte_clk,
  input  logic                             sys_rst_n,
  input  logic                             lanes_data_in_valid,
  input  logic [LANES*8-1:0]               lanes_data_in,
  input  logic                             err_clr,
  output logic                             data_out_valid,
  output logic [7:0]                       data_out,
  output logic                             data_out_sop,
  output logic                             data_out_eop,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
  output logic                             overflow_err
);
  localparam int DW = LANES*8;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH+1);
  localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(LANES-1);
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  // hold stage
  logic          hold_vld;
  logic [DW-1:0] hold_data;
  logic          push, push_last, push_ok;

  // fifo
  logic [DW:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, empty, pop;
  logic [DW:0]   head;
  logic          head_last;
  logic [DW-1:0] head_data;

  // serializer
  state_t                 state, state_nxt;
  logic [IW-1:0]          idx, idx_nxt;
  logic [LANES-1:0][7:0]  shreg;
  logic                   word_last, word_sop, first_flag;
  logic                   vld_nxt, sop_nxt, eop_nxt;
  logic [7:0]             data_nxt;

  // A word's "last" is only known once the following cycle's valid is seen.
  assign push      = hold_vld;
  assign push_last = ~lanes_data_in_valid;
  assign full      = (fifo_level == FULL_LVL);
  assign empty     = (fifo_level == '0);
  // A pop in the same cycle frees the slot, so push is still accepted when full.
  assign push_ok   = push & (~full | pop);
  assign head      = mem[rd_ptr];
  assign head_last = head[DW];
  assign head_data = head[DW-1:0];

  // Hold register: capture every valid word, release it one edge later.
  always_ff @(posedge byte_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hold_vld  <= 1'b0;
      hold_data <= '0;
    end else begin
      hold_vld <= lanes_data_in_valid;
      if (lanes_data_in_valid) hold_data <= lanes_data_in;
    end
  end

  // FIFO storage; contents are qualified by the level, so no reset needed.
  always_ff @(posedge byte_clk) begin
    if (push_ok) mem[wr_ptr] <= {push_last, hold_data};
  end

  // FIFO pointers, level and sticky overflow flag.
  always_ff @(posedge byte_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_level   <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      unique case ({push_ok, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
      if (push && !push_ok)  overflow_err <= 1'b1;
      else if (err_clr)      overflow_err <= 1'b0;
    end
  end

  // Serializer state register, shift word and registered outputs.
  always_ff @(posedge byte_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state          <= IDLE;
      idx            <= '0;
      shreg          <= '0;
      word_last      <= 1'b0;
      word_sop       <= 1'b0;
      first_flag     <= 1'b1;
      data_out_valid <= 1'b0;
      data_out       <= '0;
      data_out_sop   <= 1'b0;
      data_out_eop   <= 1'b0;
    end else begin
      state          <= state_nxt;
      idx            <= idx_nxt;
      data_out_valid <= vld_nxt;
      data_out       <= data_nxt;
      data_out_sop   <= sop_nxt;
      data_out_eop   <= eop_nxt;
      if (pop) begin
        shreg      <= head_data;
        word_last  <= head_last;
        word_sop   <= first_flag;
        first_flag <= head_last;
      end
    end
  end

  // Next state and next outputs; the last byte of a word pops the next one so
  // its lane0 byte follows without a bubble.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    pop       = 1'b0;
    vld_nxt   = 1'b0;
    data_nxt  = '0;
    sop_nxt   = 1'b0;
    eop_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          vld_nxt  = 1'b1;
          data_nxt = head_data[7:0];
          sop_nxt  = first_flag;
          eop_nxt  = (LANES == 1) && head_last;
          idx_nxt  = IW'(1);
          if (LANES > 1) state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        vld_nxt  = 1'b1;
        data_nxt = shreg[idx];
        sop_nxt  = (idx == '0) && word_sop;
        eop_nxt  = (idx == LAST_IDX) && word_last;
        if (idx == LAST_IDX) begin
          if (!empty) begin
            pop     = 1'b1;
            idx_nxt = '0;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          idx_nxt = idx + IW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule
